// File: rtl/rsc_dec_source.sv
// Duobinary RSC decoder input stage: ping-pong frame buffer with parity depuncturing.
module rsc_dec_source #(
  parameter int unsigned pLLR_W  = 5,
  parameter int unsigned pTAG_W  = 8,
  parameter int unsigned pN_MAX  = 4096,
  localparam int unsigned pADDR_W = $clog2(pN_MAX)
) (
  input  logic                  iclk,
  input  logic                  ireset,
  input  logic                  iclkena,
  input  logic [2:0]            icode,
  input  logic [pADDR_W:0]      iN,
  input  logic                  isop,
  input  logic                  ieop,
  input  logic                  ival,
  input  logic [2*pLLR_W-1:0]   idat,
  input  logic [pTAG_W-1:0]     itag,
  output logic                  ordy,
  output logic                  ofull,
  output logic                  orval,
  input  logic [pADDR_W-1:0]    iraddr,
  input  logic                  irdone,
  output logic [2*pLLR_W-1:0]   osys,
  output logic [2*pLLR_W-1:0]   oy,
  output logic [2*pLLR_W-1:0]   ow,
  output logic [pADDR_W:0]      oN,
  output logic [2:0]            ocode,
  output logic [pTAG_W-1:0]     otag,
  output logic                  oerr
);

  localparam int unsigned DAT_W = 2 * pLLR_W;
  localparam int unsigned CNT_W = pADDR_W + 1;
  localparam int unsigned MEM_D = 2 * pN_MAX;

  typedef enum logic [2:0] {S_IDLE, S_SYS, S_YPAR, S_WPAR, S_WAIT_EOP} state_t;

  // Y puncturing period per code rate; undefined codes behave like period 1
  function automatic logic [2:0] y_period(input logic [2:0] code);
    case (code)
      3'd3:    y_period = 3'd2;
      3'd4:    y_period = 3'd3;
      3'd5:    y_period = 3'd4;
      3'd6:    y_period = 3'd6;
      default: y_period = 3'd1;
    endcase
  endfunction

  // Buffer storage, one bank pair per RAM selected by the buffer pointer MSB
  logic [DAT_W-1:0] sys_mem [MEM_D];
  logic [DAT_W-1:0] y_mem   [MEM_D];
  logic [DAT_W-1:0] w_mem   [MEM_D];

  state_t             state;
  logic [2:0]         cur_code;
  logic [CNT_W-1:0]   cur_n;
  logic [pTAG_W-1:0]  cur_tag;
  logic [2:0]         y_step;
  logic [1:0]         w_step;
  logic               w_en;
  logic [CNT_W-1:0]   k_cnt;
  logic [CNT_W-1:0]   y_addr;
  logic [CNT_W-1:0]   w_addr;

  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         buf_full;
  logic [CNT_W-1:0]   d_n    [2];
  logic [2:0]         d_code [2];
  logic [pTAG_W-1:0]  d_tag  [2];
  logic [1:0]         d_err;

  logic               acc_c;
  logic               start_c;
  logic               commit_c;
  logic               release_c;
  logic               last_c;
  logic               sel_new_c;
  logic               wr_nxt_c;
  logic               rd_nxt_c;
  logic [1:0]         full_nxt_c;
  logic [CNT_W-1:0]   y_next_c;
  logic [CNT_W-1:0]   w_next_c;
  logic               sys_we_c;
  logic               y_we_c;
  logic               w_we_c;
  logic [pADDR_W-1:0] sys_a_c;
  logic [pADDR_W-1:0] y_a_c;
  logic [pADDR_W-1:0] w_a_c;
  logic [DAT_W-1:0]   y_d_c;
  logic [DAT_W-1:0]   w_d_c;

  assign acc_c    = ival && ordy;
  assign start_c  = acc_c && isop;
  assign y_next_c = y_addr + CNT_W'(y_step);
  assign w_next_c = w_addr + CNT_W'(w_step);

  // Debit routing, RAM write strobes, commit/release and next buffer status
  always_comb begin
    sys_we_c   = 1'b0;
    y_we_c     = 1'b0;
    w_we_c     = 1'b0;
    sys_a_c    = '0;
    y_a_c      = '0;
    w_a_c      = '0;
    y_d_c      = '0;
    w_d_c      = '0;
    last_c     = 1'b0;
    if (start_c) begin
      sys_we_c = 1'b1;
      y_we_c   = 1'b1;
      w_we_c   = 1'b1;
    end else if (acc_c) begin
      case (state)
        S_SYS: begin
          sys_we_c = 1'b1;
          y_we_c   = 1'b1;
          w_we_c   = 1'b1;
          sys_a_c  = k_cnt[pADDR_W-1:0];
          y_a_c    = k_cnt[pADDR_W-1:0];
          w_a_c    = k_cnt[pADDR_W-1:0];
        end
        S_YPAR: begin
          y_we_c = 1'b1;
          y_a_c  = y_addr[pADDR_W-1:0];
          y_d_c  = idat;
          last_c = (y_next_c >= cur_n) && !w_en;
        end
        S_WPAR: begin
          w_we_c = 1'b1;
          w_a_c  = w_addr[pADDR_W-1:0];
          w_d_c  = idat;
          last_c = (w_next_c >= cur_n);
        end
        default: ;
      endcase
    end
    commit_c   = acc_c && ieop && !isop && (state != S_IDLE);
    release_c  = irdone && buf_full[rd_ptr];
    full_nxt_c = buf_full;
    if (commit_c)  full_nxt_c[wr_ptr] = 1'b1;
    if (release_c) full_nxt_c[rd_ptr] = 1'b0;
    wr_nxt_c   = wr_ptr ^ commit_c;
    rd_nxt_c   = rd_ptr ^ release_c;
    sel_new_c  = commit_c && (wr_ptr == rd_nxt_c);
  end

  // Buffer RAM writes into the current write buffer
  always_ff @(posedge iclk) begin
    if (!ireset && iclkena) begin
      if (sys_we_c) sys_mem[{wr_ptr, sys_a_c}] <= idat;
      if (y_we_c)   y_mem[{wr_ptr, y_a_c}]     <= y_d_c;
      if (w_we_c)   w_mem[{wr_ptr, w_a_c}]     <= w_d_c;
    end
  end

  // Registered read port of the current read buffer
  always_ff @(posedge iclk) begin
    if (ireset) begin
      osys <= '0;
      oy   <= '0;
      ow   <= '0;
    end else if (iclkena) begin
      osys <= sys_mem[{rd_ptr, iraddr}];
      oy   <= y_mem[{rd_ptr, iraddr}];
      ow   <= w_mem[{rd_ptr, iraddr}];
    end
  end

  // Write FSM, buffer ownership and registered status/descriptor outputs
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state    <= S_IDLE;
      cur_code <= '0;
      cur_n    <= '0;
      cur_tag  <= '0;
      y_step   <= 3'd1;
      w_step   <= 2'd1;
      w_en     <= 1'b0;
      k_cnt    <= '0;
      y_addr   <= '0;
      w_addr   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      buf_full <= '0;
      d_err    <= '0;
      for (int i = 0; i < 2; i++) begin
        d_n[i]    <= '0;
        d_code[i] <= '0;
        d_tag[i]  <= '0;
      end
      ordy     <= 1'b1;
      ofull    <= 1'b0;
      orval    <= 1'b0;
      oN       <= '0;
      ocode    <= '0;
      otag     <= '0;
      oerr     <= 1'b0;
    end else if (iclkena) begin
      buf_full <= full_nxt_c;
      wr_ptr   <= wr_nxt_c;
      rd_ptr   <= rd_nxt_c;
      ordy     <= !full_nxt_c[wr_nxt_c];
      ofull    <= &full_nxt_c;
      orval    <= full_nxt_c[rd_nxt_c];

      if (commit_c) begin
        d_n[wr_ptr]    <= cur_n;
        d_code[wr_ptr] <= cur_code;
        d_tag[wr_ptr]  <= cur_tag;
        d_err[wr_ptr]  <= !last_c;
      end

      oN    <= sel_new_c ? cur_n    : d_n[rd_nxt_c];
      ocode <= sel_new_c ? cur_code : d_code[rd_nxt_c];
      otag  <= sel_new_c ? cur_tag  : d_tag[rd_nxt_c];
      oerr  <= sel_new_c ? !last_c  : d_err[rd_nxt_c];

      if (start_c) begin
        cur_code <= icode;
        cur_n    <= iN;
        cur_tag  <= itag;
        y_step   <= y_period(icode);
        w_step   <= (icode == 3'd0) ? 2'd1 : 2'd2;
        w_en     <= (icode <= 3'd1);
        k_cnt    <= CNT_W'(1);
        y_addr   <= '0;
        w_addr   <= '0;
        state    <= (iN == CNT_W'(1)) ? S_YPAR : S_SYS;
      end else if (acc_c) begin
        case (state)
          S_SYS: begin
            if (k_cnt == cur_n - CNT_W'(1)) state <= S_YPAR;
            else                            k_cnt <= k_cnt + CNT_W'(1);
          end
          S_YPAR: begin
            if (y_next_c >= cur_n) state <= w_en ? S_WPAR : S_WAIT_EOP;
            else                   y_addr <= y_next_c;
          end
          S_WPAR: begin
            if (w_next_c >= cur_n) state <= S_WAIT_EOP;
            else                   w_addr <= w_next_c;
          end
          default: ;
        endcase
        if (commit_c) state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_rsc_dec_source.sv
// Randomized self-checking bench for rsc_dec_source against a frame-level model.
module tb_rsc_dec_source;

  localparam int unsigned DAT_W = 10;

  logic              clk = 1'b0;
  logic              ireset;
  logic              iclkena;
  logic [2:0]        icode;
  logic [12:0]       iN;
  logic              isop;
  logic              ieop;
  logic              ival;
  logic [DAT_W-1:0]  idat;
  logic [7:0]        itag;
  logic              ordy;
  logic              ofull;
  logic              orval;
  logic [11:0]       iraddr;
  logic              irdone;
  logic [DAT_W-1:0]  osys;
  logic [DAT_W-1:0]  oy;
  logic [DAT_W-1:0]  ow;
  logic [12:0]       oN;
  logic [2:0]        ocode;
  logic [7:0]        otag;
  logic              oerr;

  rsc_dec_source dut (
    .iclk(clk), .ireset(ireset), .iclkena(iclkena), .icode(icode), .iN(iN),
    .isop(isop), .ieop(ieop), .ival(ival), .idat(idat), .itag(itag),
    .ordy(ordy), .ofull(ofull), .orval(orval), .iraddr(iraddr), .irdone(irdone),
    .osys(osys), .oy(oy), .ow(ow), .oN(oN), .ocode(ocode), .otag(otag), .oerr(oerr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Frame-level model: committed frames in arrival order
  logic [DAT_W-1:0] m_sys [16][64];
  logic [DAT_W-1:0] m_y   [16][64];
  logic [DAT_W-1:0] m_w   [16][64];
  int               m_n    [16];
  int               m_code [16];
  int               m_tag  [16];
  int               m_err  [16];
  int               pend[$];
  int               fid = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int period(input int code);
    case (code)
      3: return 2;
      4: return 3;
      5: return 4;
      6: return 6;
      default: return 1;
    endcase
  endfunction

  function automatic int n_w(input int code, input int n);
    if (code == 0) return n;
    if (code == 1) return (n + 1) / 2;
    return 0;
  endfunction

  function automatic int frame_len(input int code, input int n);
    int p = period(code);
    return n + (n + p - 1) / p + n_w(code, n);
  endfunction

  task automatic idle_inputs();
    ival = 1'b0; isop = 1'b0; ieop = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    ireset = 1'b1; idle_inputs(); irdone = 1'b0;
    repeat (2) @(negedge clk);
    ireset = 1'b0;
    pend.delete();
  endtask

  // Drive one frame of ndeb debits; abort=1 leaves it without ieop
  task automatic send_frame(input int code, input int n, input int tag,
                            input int ndeb, input bit abort, input bit gaps);
    int p, ny, nwv, ws, slot, len;
    bit acc;
    logic [DAT_W-1:0] d;
    p    = period(code);
    ny   = (n + p - 1) / p;
    nwv  = n_w(code, n);
    ws   = (code == 0) ? 1 : 2;
    len  = frame_len(code, n);
    slot = fid % 16;
    for (int k = 0; k < 64; k++) begin
      m_sys[slot][k] = '0; m_y[slot][k] = '0; m_w[slot][k] = '0;
    end
    acc = 1'b0;
    for (int i = 0; i < ndeb; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        idle_inputs();
      end
      @(negedge clk);
      if (i == 0) begin
        acc = (pend.size() < 2);
        check("ordy_at_sop", ordy, acc);
      end
      d     = DAT_W'($urandom);
      ival  = 1'b1;
      idat  = d;
      isop  = (i == 0);
      ieop  = (i == ndeb - 1) && !abort;
      icode = 3'(code);
      iN    = 13'(n);
      itag  = 8'(tag);
      if (i < n)                   m_sys[slot][i] = d;
      else if (i < n + ny)         m_y[slot][(i - n) * p] = d;
      else if (i < n + ny + nwv)   m_w[slot][(i - n - ny) * ws] = d;
    end
    @(negedge clk);
    idle_inputs();
    if (acc && !abort) begin
      m_n[slot]    = n;
      m_code[slot] = code;
      m_tag[slot]  = tag;
      m_err[slot]  = (ndeb != len) ? 1 : 0;
      pend.push_back(fid);
      fid++;
    end
  endtask

  // Read the oldest committed frame, compare every duobit, then release it
  task automatic read_frame();
    int to, slot, n;
    to = 0;
    @(negedge clk);
    while (!orval && to < 20) begin
      @(negedge clk);
      to++;
    end
    check("orval_ready", orval, 1);
    if (pend.size() == 0) return;
    slot = pend[0] % 16;
    n    = m_n[slot];
    check("oN", oN, n);
    check("ocode", ocode, m_code[slot]);
    check("otag", otag, m_tag[slot]);
    check("oerr", oerr, m_err[slot]);
    iraddr = 12'd0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check($sformatf("osys[%0d]", k), osys, m_sys[slot][k]);
      check($sformatf("oy[%0d]", k), oy, m_y[slot][k]);
      check($sformatf("ow[%0d]", k), ow, m_w[slot][k]);
      if (k + 1 < n) iraddr = 12'(k + 1);
    end
    irdone = 1'b1;
    @(negedge clk);
    irdone = 1'b0;
    void'(pend.pop_front());
    check("orval_after_done", orval, (pend.size() > 0));
  endtask

  initial begin
    int code, n, len, r, nd;
    ireset = 1'b1; iclkena = 1'b1; icode = '0; iN = '0; idle_inputs();
    idat = '0; itag = '0; iraddr = '0; irdone = 1'b0;
    apply_reset();
    check("rst_ordy", ordy, 1);
    check("rst_ofull", ofull, 0);
    check("rst_orval", orval, 0);
    check("rst_oerr", oerr, 0);
    check("rst_osys", osys, 0);
    check("rst_oy", oy, 0);
    check("rst_ow", ow, 0);
    check("rst_oN", oN, 0);
    check("rst_otag", otag, 0);

    // Release while empty must be ignored
    irdone = 1'b1;
    @(negedge clk);
    irdone = 1'b0;
    @(negedge clk);
    check("rdone_empty_orval", orval, 0);
    check("rdone_empty_ordy", ordy, 1);

    // Rate 1/3, rate 2/3, rate 6/7 and rate 2/5 frames
    send_frame(0, 8, 8'h11, 24, 1'b0, 1'b0);
    read_frame();
    send_frame(3, 8, 8'h22, 12, 1'b0, 1'b0);
    read_frame();
    send_frame(6, 7, 8'h33, 9, 1'b0, 1'b0);
    read_frame();
    send_frame(1, 5, 8'h44, 13, 1'b0, 1'b0);
    read_frame();

    // Back-to-back frames until both buffers are full
    send_frame(2, 4, 8'hA1, 8, 1'b0, 1'b0);
    send_frame(4, 6, 8'hB2, 8, 1'b0, 1'b0);
    check("both_full_ordy", ordy, 0);
    check("both_full_ofull", ofull, 1);
    send_frame(5, 5, 8'hC3, 7, 1'b0, 1'b0);
    read_frame();
    check("after_done_ordy", ordy, 1);
    check("after_done_ofull", ofull, 0);
    send_frame(5, 5, 8'hC3, 7, 1'b0, 1'b0);
    read_frame();
    read_frame();

    // Length errors: early eop and overlong frame
    send_frame(2, 8, 8'h55, 10, 1'b0, 1'b0);
    read_frame();
    send_frame(2, 8, 8'h66, 20, 1'b0, 1'b0);
    read_frame();

    // Mid-frame restart keeps only the second frame
    send_frame(2, 8, 8'h77, 5, 1'b1, 1'b0);
    send_frame(2, 8, 8'h78, 16, 1'b0, 1'b0);
    read_frame();
    check("restart_only_one", orval, 0);

    // Reset mid-frame with a committed frame pending
    send_frame(0, 3, 8'h88, 9, 1'b0, 1'b0);
    send_frame(0, 3, 8'h89, 4, 1'b1, 1'b0);
    apply_reset();
    check("midrst_ordy", ordy, 1);
    check("midrst_orval", orval, 0);
    check("midrst_ofull", ofull, 0);

    // Randomized frames, lengths and gaps
    for (int f = 0; f < 24; f++) begin
      for (int s = 0; s < 2; s++) begin
        if (s == 1 && $urandom_range(0, 1) == 0) break;
        code = $urandom_range(0, 6);
        n    = $urandom_range(1, 40);
        len  = frame_len(code, n);
        r    = $urandom_range(0, 3);
        if (r == 0)      nd = n + $urandom_range(0, len - n);
        else if (r == 1) nd = len + $urandom_range(1, 4);
        else             nd = len;
        send_frame(code, n, $urandom_range(0, 255), nd, 1'b0, 1'b1);
      end
      while (pend.size() > 0) read_frame();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
